// File: rtl/video_stream_sequencer_pkg.sv
// Shared timing constants, segment encoding and XY code helper
// for the BT.656-style video stream sequencer.
package video_timing_pkg;

    localparam int H_ACTIVE = 1440;
    localparam int H_BLANK  = 268;

    localparam logic [9:0] V_TOTAL   = 10'd525;
    localparam logic [9:0] VB1_END   = 10'd19;
    localparam logic [9:0] VB2_START = 10'd264;
    localparam logic [9:0] VB2_END   = 10'd282;
    localparam logic [9:0] F0_START  = 10'd4;
    localparam logic [9:0] F0_END    = 10'd265;

    localparam logic [7:0] TRS_FF   = 8'hFF;
    localparam logic [7:0] TRS_00   = 8'h00;
    localparam logic [7:0] BLK_CB   = 8'h80;
    localparam logic [7:0] BLK_Y    = 8'h10;
    localparam logic [7:0] CLAMP_LO = 8'h10;
    localparam logic [7:0] CLAMP_HI = 8'hF0;

    typedef enum logic [1:0] {
        ST_EAV,
        ST_HBLANK,
        ST_SAV,
        ST_ACTIVE
    } seg_e;

    function automatic logic [7:0] xy_code(input logic f,
                                           input logic v,
                                           input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/video_stream_sequencer_byte_clamp.sv
// Combinational clamp of an 8-bit sample into the legal
// video range so only timing codes carry 0x00/0xFF.
module byte_clamp
    import video_timing_pkg::*;
(
    input  logic [7:0] d_i,
    output logic [7:0] q_o
);

    always_comb begin
        q_o = d_i;
        if (d_i < CLAMP_LO) q_o = CLAMP_LO;
        else if (d_i > CLAMP_HI) q_o = CLAMP_HI;
    end

endmodule

// File: rtl/video_stream_sequencer.sv
// BT.656 4:2:2 byte stream generator: H/V timing, EAV/SAV,
// blanking levels and per-frame splash/game source selection.
module video_stream_sequencer
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE_P = H_ACTIVE,
    parameter int H_BLANK_P  = H_BLANK
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sel_game_i,
    input  logic [7:0] splash_data_i,
    input  logic [7:0] game_data_i,
    output logic       request_o,
    output logic [7:0] dout_o,
    output logic [9:0] line_o,
    output logic       field_o,
    output logic       src_sel_o,
    output logic       frame_start_o
);

    localparam int H_TOTAL   = 8 + H_BLANK_P + H_ACTIVE_P;
    localparam int SAV_START = 4 + H_BLANK_P;
    localparam int ACT_START = SAV_START + 4;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] EAV_LAST  = 11'd3;
    localparam logic [10:0] HBL_LAST  = 11'(SAV_START - 1);
    localparam logic [10:0] SAV_LAST  = 11'(ACT_START - 1);
    localparam logic [10:0] REQ_FIRST = 11'(ACT_START - 1);
    localparam logic [10:0] REQ_LAST  = 11'(H_TOTAL - 2);

    logic [10:0] h_q, h_d;
    logic [9:0]  line_q, line_d;
    logic        field_q, field_d;
    logic        v_q, v_d;
    logic        src_q, src_d;
    logic        req_q, req_d;
    logic        fs_q, fs_d;
    logic [7:0]  dout_q, dout_d;
    seg_e        st_q, st_d;

    logic       h_wrap;
    logic       frame_end;
    logic [7:0] src_byte;
    logic [7:0] clamped;
    logic [7:0] blank;
    logic [7:0] code;

    assign h_wrap    = (h_q == H_LAST);
    assign frame_end = h_wrap && (line_q == V_TOTAL);
    assign src_byte  = src_q ? game_data_i : splash_data_i;

    byte_clamp u_clamp (
        .d_i (src_byte),
        .q_o (clamped)
    );

    always_comb begin
        h_d     = h_wrap ? 11'd0 : h_q + 11'd1;
        line_d  = line_q;
        if (h_wrap) begin
            line_d = (line_q == V_TOTAL) ? 10'd1 : line_q + 10'd1;
        end
        field_d = !((line_d >= F0_START) && (line_d <= F0_END));
        v_d     = (line_d <= VB1_END) ||
                  ((line_d >= VB2_START) && (line_d <= VB2_END));
        src_d   = frame_end ? sel_game_i : src_q;
        fs_d    = frame_end;
        // Request leads each active byte by one cycle; V is stable mid-line.
        req_d   = !v_q && (h_d >= REQ_FIRST) && (h_d <= REQ_LAST);
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_EAV:    if (h_q == EAV_LAST) st_d = ST_HBLANK;
            ST_HBLANK: if (h_q == HBL_LAST) st_d = ST_SAV;
            ST_SAV:    if (h_q == SAV_LAST) st_d = ST_ACTIVE;
            ST_ACTIVE: if (h_wrap)          st_d = ST_EAV;
        endcase
    end

    always_comb begin
        blank = h_q[0] ? BLK_Y : BLK_CB;
        code  = TRS_00;
        unique case (1'b1)
            (h_q[1:0] == 2'd0): code = TRS_FF;
            (h_q[1:0] == 2'd3): code = xy_code(field_q, v_q, st_q == ST_EAV);
            default:            code = TRS_00;
        endcase
        dout_d = blank;
        unique case (st_q)
            ST_EAV:    dout_d = code;
            ST_HBLANK: dout_d = blank;
            ST_SAV:    dout_d = code;
            ST_ACTIVE: dout_d = v_q ? blank : clamped;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q     <= 11'd0;
            line_q  <= 10'd1;
            field_q <= 1'b1;
            v_q     <= 1'b1;
            src_q   <= 1'b0;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            dout_q  <= BLK_Y;
            st_q    <= ST_EAV;
        end else begin
            h_q     <= h_d;
            line_q  <= line_d;
            field_q <= field_d;
            v_q     <= v_d;
            src_q   <= src_d;
            req_q   <= req_d;
            fs_q    <= fs_d;
            dout_q  <= dout_d;
            st_q    <= st_d;
        end
    end

    assign request_o     = req_q;
    assign dout_o        = dout_q;
    assign line_o        = line_q;
    assign field_o       = field_q;
    assign src_sel_o     = src_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_video_stream_sequencer.sv
// Directed bench for video_stream_sequencer, run with a short
// line (32 active + 8 blank bytes) to keep full frames cheap.
module tb_video_stream_sequencer;

    localparam int HA = 32;
    localparam int HB = 8;
    localparam int HT = 8 + HB + HA;
    localparam int SS = 4 + HB;
    localparam int AS = SS + 4;
    localparam int FT = 525 * HT;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic [7:0] splash;
    logic [7:0] game;
    logic       request_o;
    logic [7:0] dout_o;
    logic [9:0] line_o;
    logic       field_o;
    logic       src_sel_o;
    logic       frame_start_o;

    int n_tot;
    int n_bad;
    int e;
    int fbase;
    int req_cnt;
    int fs_cnt;
    logic exp_src;

    video_stream_sequencer #(
        .H_ACTIVE_P (HA),
        .H_BLANK_P  (HB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sel_game_i    (sel),
        .splash_data_i (splash),
        .game_data_i   (game),
        .request_o     (request_o),
        .dout_o        (dout_o),
        .line_o        (line_o),
        .field_o       (field_o),
        .src_sel_o     (src_sel_o),
        .frame_start_o (frame_start_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] want);
        n_tot++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] clampb(input logic [7:0] x);
        if (x < 8'h10) return 8'h10;
        if (x > 8'hF0) return 8'hF0;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
        if (request_o) req_cnt++;
        if (frame_start_o) fs_cnt++;
    endtask

    task automatic goto(input int ln, input int h);
        int target;
        target = fbase + (ln - 1) * HT + h;
        while (e < target) tick();
    endtask

    // Starts at (ln, h=0); checks every byte of the line.
    task automatic scan_line(input int ln,
                             input logic [7:0] sav,
                             input logic [7:0] eav,
                             input bit ramp);
        int r0;
        logic [7:0] want;
        logic act;
        act = !sav[5];
        check($sformatf("line L%0d", ln), 32'(line_o), ln);
        check($sformatf("field L%0d", ln), 32'(field_o), 32'(eav[6]));
        r0 = req_cnt;
        for (int h = 0; h < HT; h++) begin
            if (ramp && h >= AS) begin
                splash = 8'((h - AS) * 8);
                game   = 8'((h - AS) * 8);
            end
            if (h < 4)
                want = (h == 0) ? 8'hFF : (h == 3) ? eav : 8'h00;
            else if (h < SS)
                want = ((h - 4) % 2 != 0) ? 8'h10 : 8'h80;
            else if (h < AS)
                want = (h == SS) ? 8'hFF : (h == SS + 3) ? sav : 8'h00;
            else if (!act)
                want = ((h - AS) % 2 != 0) ? 8'h10 : 8'h80;
            else
                want = clampb(exp_src ? game : splash);
            tick();
            check($sformatf("dout L%0d h%0d", ln, h), 32'(dout_o), 32'(want));
        end
        check($sformatf("reqs L%0d", ln), req_cnt - r0, act ? HA : 0);
    endtask

    initial begin
        n_tot = 0; n_bad = 0; e = 0; fbase = 0;
        req_cnt = 0; fs_cnt = 0; exp_src = 1'b0;
        rst_n = 1'b0; sel = 1'b0; splash = 8'h55; game = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst dout", 32'(dout_o), 32'h10);
        check("rst req", 32'(request_o), 0);
        check("rst fs", 32'(frame_start_o), 0);
        check("rst field", 32'(field_o), 1);
        check("rst src", 32'(src_sel_o), 0);
        check("rst line", 32'(line_o), 1);

        rst_n = 1'b1; e = 0; req_cnt = 0; fs_cnt = 0;
        scan_line(1, 8'hEC, 8'hF1, 1'b0);
        goto(20, 0);
        check("vblank reqs", req_cnt, 0);
        scan_line(20, 8'h80, 8'h9D, 1'b1);
        splash = 8'h55;
        goto(100, 0);
        scan_line(100, 8'h80, 8'h9D, 1'b0);

        goto(200, 0);
        sel = 1'b1; game = 8'hA0; splash = 8'h30;
        scan_line(200, 8'h80, 8'h9D, 1'b0);
        check("src mid", 32'(src_sel_o), 0);
        goto(265, 0);
        check("field 265", 32'(field_o), 0);
        goto(266, 0);
        check("field 266", 32'(field_o), 1);
        goto(300, 0);
        scan_line(300, 8'hC7, 8'hDA, 1'b0);

        goto(525, HT - 1);
        check("line 525", 32'(line_o), 525);
        check("fs pre", 32'(frame_start_o), 0);
        check("src pre", 32'(src_sel_o), 0);
        check("fs cnt0", fs_cnt, 0);
        tick();
        check("wrap line", 32'(line_o), 1);
        check("wrap fs", 32'(frame_start_o), 1);
        check("wrap src", 32'(src_sel_o), 1);
        check("wrap field", 32'(field_o), 1);
        tick();
        check("fs drop", 32'(frame_start_o), 0);
        fbase = FT; exp_src = 1'b1; sel = 1'b0;

        goto(3, 0);
        check("field 3", 32'(field_o), 1);
        goto(4, 0);
        check("field 4", 32'(field_o), 0);
        check("src held", 32'(src_sel_o), 1);
        goto(20, 0);
        scan_line(20, 8'h80, 8'h9D, 1'b0);
        check("fs cnt1", fs_cnt, 1);

        goto(150, 30);
        check("req pre", 32'(request_o), 1);
        rst_n = 1'b0;
        #1;
        check("arst dout", 32'(dout_o), 32'h10);
        check("arst req", 32'(request_o), 0);
        check("arst fs", 32'(frame_start_o), 0);
        check("arst line", 32'(line_o), 1);
        check("arst field", 32'(field_o), 1);
        check("arst src", 32'(src_sel_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; e = 0; fbase = 0; exp_src = 1'b0; splash = 8'h55;
        scan_line(1, 8'hEC, 8'hF1, 1'b0);
        check("fs cnt2", fs_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
